simon_round_scheduler: RTL and testbench

- Sequences one SIMON block operation end to end, between the host block interface and the shared SIMON datapath.
- Owns the key expansion unit's control: re-key reset pulse, newData/doneKey handshake and round-key caching.
- Drives an external single-cycle combinational round function once per round and returns the result over a valid/ready handshake.

---
 rtl/simon_round_scheduler.sv | 116 +++++++++++
 tb/tb_simon_round_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_scheduler.sv
// Control sequencer for one SIMON block operation: key-expansion handshake, round iteration, result handoff.
// Optional SIMON_DECRYPT_EN adds a dec input that swaps halves and reverses the round-key order.
module simon_round_scheduler #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int Cb = 5
) (
  input  logic             clk,
  input  logic             R,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2*N-1:0]   inBlock,
  input  logic [M*N-1:0]   inKey,
  input  logic             newKey,
`ifdef SIMON_DECRYPT_EN
  input  logic             dec,
`endif
  output logic             outValid,
  input  logic             outReady,
  output logic [2*N-1:0]   outBlock,
  output logic             expnR,
  output logic             expNew,
  output logic [M*N-1:0]   expKey,
  input  logic             expDone,
  input  logic [T*N-1:0]   expKeys,
  output logic [2*N-1:0]   rndIn,
  output logic [N-1:0]     rndKey,
  input  logic [2*N-1:0]   rndOut
);

  typedef enum logic [2:0] {IDLE, KRST, KREQ, ROUND, DONE} state_t;

  state_t         state, nstate;
  logic [N-1:0]   x, y, ldx, ldy;
  logic [Cb-1:0]  cnt, kidx;
  logic           keyValid, decq, accept, last, rekey;

  assign inReady  = (state == IDLE);
  assign accept   = inValid && inReady;
  assign rekey    = newKey || !keyValid;
  assign last     = (cnt == Cb'(T-1));
  assign outValid = (state == DONE);
  // KRST drops the expansion unit's reset so its sticky doneKey cannot satisfy the next KREQ.
  assign expnR    = !R && (state != KRST);
  assign rndIn    = {x, y};
  assign kidx     = decq ? (Cb'(T-1) - cnt) : cnt;
  assign rndKey   = expKeys[kidx*N +: N];
  assign outBlock = outValid ? (decq ? {y, x} : {x, y}) : '0;

`ifdef SIMON_DECRYPT_EN
  always_ff @(posedge clk or posedge R) begin
    if (R)           decq <= 1'b0;
    else if (accept) decq <= dec;
  end

  always_comb begin
    ldx = dec ? inBlock[N-1:0]   : inBlock[2*N-1:N];
    ldy = dec ? inBlock[2*N-1:N] : inBlock[N-1:0];
  end
`else
  assign decq = 1'b0;
  assign ldx  = inBlock[2*N-1:N];
  assign ldy  = inBlock[N-1:0];
`endif

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = rekey ? KRST : ROUND;
      KRST:    nstate = KREQ;
      KREQ:    if (expDone) nstate = ROUND;
      ROUND:   if (last) nstate = DONE;
      DONE:    if (outReady) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      keyValid <= 1'b0;
      expNew   <= 1'b0;
      expKey   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x   <= ldx;
          y   <= ldy;
          cnt <= '0;
          if (rekey) expKey <= inKey;
        end
        KRST: expNew <= 1'b1;
        KREQ: if (expDone) begin
          keyValid <= 1'b1;
          expNew   <= 1'b0;
          cnt      <= '0;
        end
        ROUND: begin
          {x, y} <= rndOut;
          // Hold at T-1 on the final update instead of wrapping.
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_scheduler.sv
// Directed bench for simon_round_scheduler with behavioural SIMON32/64 key expansion and round function.
module tb_simon_round_scheduler;
  localparam int N = 16, M = 4, T = 32, Cb = 5, LAT = 3;

  logic clk = 1'b0;
  logic R, inValid, inReady, newKey, outValid, outReady, expnR, expNew, expDone;
  logic [2*N-1:0] inBlock, outBlock, rndIn, rndOut;
  logic [M*N-1:0] inKey, expKey;
  logic [T*N-1:0] expKeys;
  logic [N-1:0]   rndKey;
`ifdef SIMON_DECRYPT_EN
  logic dec;
`endif

  int checks = 0, errors = 0;
  int lat, nlow, nnew;
  logic [2:0] ec;
  logic edone;
  logic [15:0] klog[$];
  logic [T*N-1:0] ks;

  always #5 clk = ~clk;

  simon_round_scheduler #(.N(N), .M(M), .T(T), .Cb(Cb)) dut (
    .clk(clk), .R(R), .inValid(inValid), .inReady(inReady), .inBlock(inBlock),
    .inKey(inKey), .newKey(newKey),
`ifdef SIMON_DECRYPT_EN
    .dec(dec),
`endif
    .outValid(outValid), .outReady(outReady), .outBlock(outBlock),
    .expnR(expnR), .expNew(expNew), .expKey(expKey), .expDone(expDone),
    .expKeys(expKeys), .rndIn(rndIn), .rndKey(rndKey), .rndOut(rndOut));

  function automatic logic [T*N-1:0] expand(input logic [M*N-1:0] key);
    logic [15:0] k[0:31];
    logic [15:0] tmp;
    logic [61:0] z;
    logic [T*N-1:0] r;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[i*16 +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp  = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      tmp  = tmp ^ {tmp[0], tmp[15:1]};
      k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) r[i*16 +: 16] = k[i];
    return r;
  endfunction

  function automatic logic [31:0] rnd(input logic [31:0] s, input logic [15:0] k);
    logic [15:0] a, f;
    a = s[31:16];
    f = ({a[14:0], a[15]} & {a[7:0], a[15:8]}) ^ {a[13:0], a[15:14]};
    return {s[15:0] ^ f ^ k, a};
  endfunction

  function automatic logic [31:0] enc(input logic [63:0] key, input logic [31:0] blk);
    logic [T*N-1:0] kk;
    logic [31:0] s;
    kk = expand(key);
    s  = blk;
    for (int i = 0; i < T; i++) s = rnd(s, kk[i*16 +: 16]);
    return s;
  endfunction

  // Key expansion unit model: sticky done, cleared only by its active-low reset.
  always_ff @(posedge clk) begin
    if (!expnR) begin
      edone <= 1'b0;
      ec    <= '0;
    end else if (expNew && !edone) begin
      if (ec == 3'(LAT-1)) edone <= 1'b1;
      ec <= ec + 3'd1;
    end
  end

  assign expDone = edone;
  assign expKeys = expand(expKey);
  assign rndOut  = rnd(rndIn, rndKey);

  // ROUND is the only state with expnR=1, expNew=0, inReady=0, outValid=0.
  always @(posedge clk)
    if (!R && expnR && !expNew && !inReady && !outValid) klog.push_back(rndKey);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [63:0] key, input logic [31:0] blk, input logic nk,
                       output int l, output int nl, output int nn);
    klog.delete();
    inKey = key; inBlock = blk; newKey = nk; inValid = 1'b1;
    tick;
    inValid = 1'b0; inKey = ~key; inBlock = ~blk; newKey = ~nk;
    l = 0; nl = 0; nn = 0;
    while (!outValid && l < 200) begin
      if (!expnR) nl++;
      if (expNew) nn++;
      tick;
      l++;
    end
    chk("op_timeout", {63'd0, outValid}, 64'd1);
  endtask

  task automatic release_out;
    outReady = 1'b1;
    tick;
    outReady = 1'b0;
    chk("idle_outValid", {63'd0, outValid}, 64'd0);
    chk("idle_inReady", {63'd0, inReady}, 64'd1);
  endtask

  initial begin
    R = 1'b1; inValid = 1'b0; newKey = 1'b0; outReady = 1'b0;
    inBlock = '0; inKey = '0;
`ifdef SIMON_DECRYPT_EN
    dec = 1'b0;
`endif
    tick; tick;
    chk("rst_inReady", {63'd0, inReady}, 64'd1);
    chk("rst_outValid", {63'd0, outValid}, 64'd0);
    chk("rst_outBlock", {32'd0, outBlock}, 64'd0);
    chk("rst_expNew", {63'd0, expNew}, 64'd0);
    chk("rst_expKey", expKey, 64'd0);
    chk("rst_expnR", {63'd0, expnR}, 64'd0);
    R = 1'b0;
    #1;
    chk("run_expnR", {63'd0, expnR}, 64'd1);

    // First request: no cached key, so rekey even with newKey=0.
    do_op(64'h1918_1110_0908_0100, 32'h6565_6877, 1'b0, lat, nlow, nnew);
    chk("op1_lat", 64'(lat), 64'd37);
    chk("op1_krst", 64'(nlow), 64'd1);
    chk("op1_kreq", 64'(nnew), 64'd4);
    chk("op1_expKey", expKey, 64'h1918_1110_0908_0100);
    chk("op1_out", {32'd0, outBlock}, 64'hc69b_e9bb);
    release_out;

    // Cached key; DONE held with backpressure.
    do_op(64'h1918_1110_0908_0100, 32'h6565_6877, 1'b0, lat, nlow, nnew);
    chk("op2_lat", 64'(lat), 64'd32);
    chk("op2_krst", 64'(nlow), 64'd0);
    chk("op2_kreq", 64'(nnew), 64'd0);
    for (int i = 0; i < 5; i++) begin
      inValid = i[0];
      tick;
      chk("hold_outValid", {63'd0, outValid}, 64'd1);
      chk("hold_out", {32'd0, outBlock}, 64'hc69b_e9bb);
      chk("hold_inReady", {63'd0, inReady}, 64'd0);
    end
    inValid = 1'b0;
    release_out;

    // New key: expKey updated, single KRST cycle, round keys in ascending order.
    do_op(64'h1111_2222_3333_4444, 32'h0123_4567, 1'b1, lat, nlow, nnew);
    ks = expand(64'h1111_2222_3333_4444);
    chk("op3_lat", 64'(lat), 64'd37);
    chk("op3_krst", 64'(nlow), 64'd1);
    chk("op3_expKey", expKey, 64'h1111_2222_3333_4444);
    chk("op3_out", {32'd0, outBlock}, {32'd0, enc(64'h1111_2222_3333_4444, 32'h0123_4567)});
    chk("op3_nkeys", 64'(klog.size()), 64'd32);
    for (int i = 0; i < 32 && i < klog.size(); i++)
      chk($sformatf("op3_rndKey%0d", i), {48'd0, klog[i]}, {48'd0, ks[i*16 +: 16]});
    release_out;

    // Reset mid-ROUND at cnt=10.
    inKey = 64'h1111_2222_3333_4444; inBlock = 32'h0123_4567; newKey = 1'b0; inValid = 1'b1;
    tick;
    inValid = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    chk("mid_rndKey", {48'd0, rndKey}, {48'd0, ks[10*16 +: 16]});
    R = 1'b1;
    #1;
    chk("midrst_expnR", {63'd0, expnR}, 64'd0);
    chk("midrst_inReady", {63'd0, inReady}, 64'd1);
    chk("midrst_outValid", {63'd0, outValid}, 64'd0);
    chk("midrst_outBlock", {32'd0, outBlock}, 64'd0);
    chk("midrst_expNew", {63'd0, expNew}, 64'd0);
    chk("midrst_expKey", expKey, 64'd0);
    chk("midrst_rndIn", {32'd0, rndIn}, 64'd0);
    tick;
    R = 1'b0;
    #1;

    // Key cache invalidated by reset: newKey=0 still rekeys.
    do_op(64'h1111_2222_3333_4444, 32'h0123_4567, 1'b0, lat, nlow, nnew);
    chk("op5_lat", 64'(lat), 64'd37);
    chk("op5_krst", 64'(nlow), 64'd1);
    chk("op5_out", {32'd0, outBlock}, {32'd0, enc(64'h1111_2222_3333_4444, 32'h0123_4567)});
    release_out;

`ifdef SIMON_DECRYPT_EN
    dec = 1'b1;
    do_op(64'h1918_1110_0908_0100, 32'hc69b_e9bb, 1'b1, lat, nlow, nnew);
    dec = 1'b0;
    ks = expand(64'h1918_1110_0908_0100);
    chk("dec_lat", 64'(lat), 64'd37);
    chk("dec_out", {32'd0, outBlock}, 64'h6565_6877);
    chk("dec_nkeys", 64'(klog.size()), 64'd32);
    for (int i = 0; i < 32 && i < klog.size(); i++)
      chk($sformatf("dec_rndKey%0d", i), {48'd0, klog[i]}, {48'd0, ks[(31-i)*16 +: 16]});
    release_out;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
